// File: rtl/uart_wb_arbiter_if.sv
// Single-beat Wishbone B4 classic link: the master modport issues the request,
// the slave modport returns read data and ack/err.
interface uart_wb_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wr_dat;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] rd_dat;
    logic              ack;
    logic              err;

    modport master (output cyc, stb, we, adr, wr_dat, sel, input  rd_dat, ack, err);
    modport slave  (input  cyc, stb, we, adr, wr_dat, sel, output rd_dat, ack, err);
endinterface

// File: rtl/uart_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with bus watchdog in front of the UART slave.
// Grant one cycle after cyc seen idle, responses combinational; the loser stalls until the owner drops cyc.
module uart_wb_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    uart_wb_arbiter_if.slave  m0,
    uart_wb_arbiter_if.slave  m1,
    uart_wb_arbiter_if.master s,
    output logic              timeout_o
);
    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);
    localparam bit WD_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, BUSY, BLOCK} state_t;

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic              own_cyc, own_stb, own_we;
    logic [ADDR_W-1:0] own_adr;
    logic [DATA_W-1:0] own_dat;
    logic [SEL_W-1:0]  own_sel;
    logic              fwd, fwd_stb, wd;
    logic              rsp_ack, rsp_err;
    logic [DATA_W-1:0] rsp_dat;

    assign own_cyc = owner ? m1.cyc    : m0.cyc;
    assign own_stb = owner ? m1.stb    : m0.stb;
    assign own_we  = owner ? m1.we     : m0.we;
    assign own_adr = owner ? m1.adr    : m0.adr;
    assign own_dat = owner ? m1.wr_dat : m0.wr_dat;
    assign own_sel = owner ? m1.sel    : m0.sel;

    // Forwarding only while granted and the owner still holds cyc.
    assign fwd     = (state == BUSY) && own_cyc;
    assign fwd_stb = fwd && own_stb;
    assign wd      = WD_EN && (cnt == CNT_LIM) && fwd_stb && !s.ack && !s.err;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0.cyc || m1.cyc) begin
                    if (m0.cyc && m1.cyc) owner_nxt = ~last;
                    else                  owner_nxt = m1.cyc;
                    last_nxt  = owner_nxt;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!own_cyc) state_nxt = IDLE;
                else if (wd)  state_nxt = BLOCK;
            end
            BLOCK: begin
                if (!own_stb) state_nxt = own_cyc ? BUSY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt = cnt;
        if (!fwd_stb || s.ack || s.err || wd) cnt_nxt = '0;
        else if (cnt != '1)                   cnt_nxt = cnt + CNT_W'(1);
    end

    // After a watchdog hit the slave sees no strobe, but address/data keep tracking the owner.
    always_comb begin
        s.cyc    = fwd;
        s.stb    = fwd_stb;
        s.we     = 1'b0;
        s.adr    = '0;
        s.wr_dat = '0;
        s.sel    = '0;
        if (fwd || (state == BLOCK)) begin
            s.we     = own_we;
            s.adr    = own_adr;
            s.wr_dat = own_dat;
            s.sel    = own_sel;
        end
    end

    assign rsp_ack = fwd_stb && s.ack;
    assign rsp_err = fwd_stb && (s.err || wd);
    assign rsp_dat = fwd ? s.rd_dat : '0;

    assign m0.ack    = rsp_ack && !owner;
    assign m0.err    = rsp_err && !owner;
    assign m0.rd_dat = owner ? '0 : rsp_dat;
    assign m1.ack    = rsp_ack && owner;
    assign m1.err    = rsp_err && owner;
    assign m1.rd_dat = owner ? rsp_dat : '0;
    assign timeout_o = wd;
endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Randomized bench for uart_wb_arbiter: transaction-level grant/response timeline model.
module tb_uart_wb_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic timeout;
    always #5 clk = ~clk;

    uart_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    uart_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
    uart_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

    uart_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .timeout_o(timeout)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        int            lat;   // wait cycles before the slave responds; > TO means never
        bit            serr;  // slave answers with err instead of ack
        int            hold;  // extra cycles the master keeps stb up after a watchdog error
    } txn_t;

    txn_t tq [2][16];
    int   tn [2];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   last_gnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic m_ack(input int m);
        return (m == 0) ? m0_if.ack : m1_if.ack;
    endfunction
    function automatic logic m_err(input int m);
        return (m == 0) ? m0_if.err : m1_if.err;
    endfunction
    function automatic logic [DW-1:0] m_rdat(input int m);
        return (m == 0) ? m0_if.rd_dat : m1_if.rd_dat;
    endfunction

    function automatic txn_t rnd_txn(input int lat, input bit serr, input int hold);
        txn_t t;
        t.we   = 1'($urandom_range(0, 1));
        t.adr  = $urandom;
        t.dat  = $urandom;
        t.sel  = SW'($urandom_range(0, (1 << SW) - 1));
        t.lat  = lat;
        t.serr = serr;
        t.hold = hold;
        return t;
    endfunction

    task automatic add_txn(input int m, input txn_t t);
        tq[m][tn[m]] = t;
        tn[m]++;
    endtask

    task automatic drive_m(input int m, input bit on, input txn_t t);
        if (m == 0) begin
            m0_if.cyc = on;  m0_if.stb = on;  m0_if.we = on & t.we;
            m0_if.adr = on ? t.adr : '0;  m0_if.wr_dat = on ? t.dat : '0;  m0_if.sel = on ? t.sel : '0;
        end else begin
            m1_if.cyc = on;  m1_if.stb = on;  m1_if.we = on & t.we;
            m1_if.adr = on ? t.adr : '0;  m1_if.wr_dat = on ? t.dat : '0;  m1_if.sel = on ? t.sel : '0;
        end
    endtask

    task automatic idle_inputs();
        txn_t z;
        z = rnd_txn(0, 1'b0, 0);
        drive_m(0, 1'b0, z);
        drive_m(1, 1'b0, z);
        s_if.ack = 1'b0;  s_if.err = 1'b0;  s_if.rd_dat = '0;
    endtask

    // Both queued masters raise cyc at cycle 0; each grant lasts until its response,
    // the master drops cyc for one cycle, the bus idles one cycle, then the next grant
    // goes to the sole requester or, under contention, to the master not granted last.
    task automatic run_round();
        int idx [2];
        int drop_at [2];
        int act, g, r, d, kind, next_g;
        bit p0, p1, active, ack_e, err_e, done;
        logic [DW-1:0] sdat;
        txn_t t;
        idx = '{0, 0};  drop_at = '{-1, -1};
        act = -1;  g = 0;  r = -1;  d = -1;  kind = 0;  next_g = 1;  done = 1'b0;
        t = rnd_txn(0, 1'b0, 0);
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (c == next_g) begin
                p0 = idx[0] < tn[0];
                p1 = idx[1] < tn[1];
                if (p0 || p1) begin
                    act = (p0 && p1) ? 1 - last_gnt : (p1 ? 1 : 0);
                    last_gnt = act;
                    t = tq[act][idx[act]];
                    g = c;
                    if (t.lat > TO) begin kind = 2; r = g + TO; end
                    else begin kind = t.serr ? 1 : 0; r = g + t.lat; end
                    d = r + 1 + ((kind == 2) ? t.hold : 0);
                    drop_at[act] = d;
                end
            end
            for (int m = 0; m < 2; m++)
                drive_m(m, (idx[m] < tn[m]) && (c != drop_at[m]), tq[m][idx[m]]);
            #1;
            active = (act >= 0) && (c >= g) && (c <= r);
            s_if.ack = 1'b0;  s_if.err = 1'b0;  s_if.rd_dat = $urandom;
            sdat = s_if.rd_dat;
            if (active && c == r && kind != 2 && s_if.stb) begin
                if (kind == 0) s_if.ack = 1'b1;
                else           s_if.err = 1'b1;
            end else if (!active && $urandom_range(0, 3) == 0) begin
                s_if.ack = 1'($urandom_range(0, 1));
                s_if.err = ~s_if.ack;
            end
            #1;
            chk("s_cyc", 64'(s_if.cyc), 64'(active));
            chk("s_stb", 64'(s_if.stb), 64'(active));
            if (active) begin
                chk("s_adr", 64'(s_if.adr), 64'(t.adr));
                chk("s_wdat", 64'(s_if.wr_dat), 64'(t.dat));
                chk("s_we", 64'(s_if.we), 64'(t.we));
                chk("s_sel", 64'(s_if.sel), 64'(t.sel));
            end
            for (int m = 0; m < 2; m++) begin
                ack_e = active && c == r && m == act && kind == 0;
                err_e = active && c == r && m == act && kind != 0;
                chk($sformatf("m%0d_ack", m), 64'(m_ack(m)), 64'(ack_e));
                chk($sformatf("m%0d_err", m), 64'(m_err(m)), 64'(err_e));
                if (ack_e) chk($sformatf("m%0d_rdat", m), 64'(m_rdat(m)), 64'(sdat));
                if (m != act) chk($sformatf("m%0d_rdat_idle", m), 64'(m_rdat(m)), 64'(0));
            end
            chk("timeout_o", 64'(timeout), 64'(active && c == r && kind == 2));
            if (act >= 0 && c == d) begin
                idx[act]++;
                next_g = d + 2;
            end
            if (idx[0] >= tn[0] && idx[1] >= tn[1] && c == d + 1) done = 1'b1;
        end
        if (!done) chk("round_budget", 64'(0), 64'(1));
        tn = '{0, 0};
    endtask

    task automatic mid_reset();
        txn_t t;
        t = rnd_txn(TO + 5, 1'b0, 0);
        @(negedge clk);
        drive_m(1, 1'b1, t);
        @(negedge clk);
        @(negedge clk);
        #1 chk("pre_rst_stb", 64'(s_if.stb), 64'(1));
        chk("pre_rst_adr", 64'(s_if.adr), 64'(t.adr));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_s_cyc", 64'(s_if.cyc), 64'(0));
        chk("rst_s_stb", 64'(s_if.stb), 64'(0));
        chk("rst_s_adr", 64'(s_if.adr), 64'(0));
        chk("rst_s_wdat", 64'(s_if.wr_dat), 64'(0));
        s_if.ack = 1'b1;  s_if.err = 1'b1;  s_if.rd_dat = $urandom;
        drive_m(0, 1'b1, t);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rst_m%0d_ack", m), 64'(m_ack(m)), 64'(0));
            chk($sformatf("rst_m%0d_err", m), 64'(m_err(m)), 64'(0));
            chk($sformatf("rst_m%0d_rdat", m), 64'(m_rdat(m)), 64'(0));
        end
        chk("rst_timeout", 64'(timeout), 64'(0));
        @(negedge clk);
        chk("rst_hold_cyc", 64'(s_if.cyc), 64'(0));
        idle_inputs();
        rst_n = 1'b1;
        last_gnt = 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL sim_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, n1;
        txn_t t;
        tn = '{0, 0};
        last_gnt = 1;
        rst_n = 1'b0;
        idle_inputs();
        #3;
        chk("reset_s_cyc", 64'(s_if.cyc), 64'(0));
        chk("reset_s_stb", 64'(s_if.stb), 64'(0));
        chk("reset_timeout", 64'(timeout), 64'(0));
        t = rnd_txn(0, 1'b0, 0);
        drive_m(0, 1'b1, t);  drive_m(1, 1'b1, t);
        s_if.ack = 1'b1;  s_if.err = 1'b1;
        #1;
        chk("reset_m0_ack", 64'(m0_if.ack), 64'(0));
        chk("reset_m1_err", 64'(m1_if.err), 64'(0));
        chk("reset_s_cyc_req", 64'(s_if.cyc), 64'(0));
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // contention straight out of reset: m0 first, then m1
        add_txn(0, rnd_txn(0, 1'b0, 0));
        add_txn(1, rnd_txn(1, 1'b0, 0));
        run_round();

        // single-master write of 0xA5 to address 0x4
        t = rnd_txn(1, 1'b0, 0);
        t.we = 1'b1;  t.adr = 32'h4;  t.dat = 32'hA5;  t.sel = '1;
        add_txn(0, t);
        run_round();

        // continuous requests from both: 8 strictly alternating grants
        for (int i = 0; i < 4; i++) begin
            add_txn(0, rnd_txn($urandom_range(0, 3), 1'b0, 0));
            add_txn(1, rnd_txn($urandom_range(0, 3), 1'b0, 0));
        end
        run_round();

        // slave never answers; m0 keeps stb two cycles after the error
        add_txn(0, rnd_txn(TO + 3, 1'b0, 2));
        run_round();

        // ack exactly in the cycle the watchdog would fire, then one cycle later
        add_txn(0, rnd_txn(TO, 1'b0, 0));
        add_txn(1, rnd_txn(TO + 1, 1'b0, 0));
        run_round();

        for (int k = 0; k < 25; k++) begin
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 + n1 == 0) n1 = 1;
            for (int i = 0; i < n0; i++)
                add_txn(0, rnd_txn($urandom_range(0, TO + 2), $urandom_range(0, 3) == 0, $urandom_range(0, 2)));
            for (int i = 0; i < n1; i++)
                add_txn(1, rnd_txn($urandom_range(0, TO + 2), $urandom_range(0, 3) == 0, $urandom_range(0, 2)));
            run_round();
        end

        // reset while m1 owns the bus, then contention again favours m0
        mid_reset();
        add_txn(0, rnd_txn(2, 1'b0, 0));
        add_txn(1, rnd_txn(0, 1'b0, 0));
        run_round();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
